mips_multicycle_core: RTL

- Multi-cycle successor to the team's single-cycle MIPS core. One FSM sequences fetch, decode, execute, memory and write-back over several clocks.
- Uses a single unified instruction/data memory port with a req/ready handshake, so IM/DM latency may vary. The register file is internal.
- Sits between the top-level testbench/SoC and a shared memory model. Exposes debug write-back ports for checking.

---
 rtl/mips_multicycle_core.sv | 334 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//
// Multi-cycle MIPS subset core. A single FSM steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Instruction and data accesses
// share one memory port. The register file is internal.
//
// Handshake: a memory transaction completes in any cycle where
// mem_req && mem_ready. While mem_req is high and mem_ready is low,
// mem_addr, mem_we and mem_wdata are held stable. A transaction cut short
// by rst is simply dropped.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   mem_req/mem_we       memory request / write strobe (registered)
//   mem_addr/mem_wdata   word-aligned byte address / store data (registered)
//   mem_ready/mem_rdata  completion strobe / read data from memory
//   halted               core stopped in HALT (sticky until reset)
//   dbg_we/waddr/wdata   one-cycle pulse per register write (never for $0)
//   dbg_pc               PC of the instruction currently in flight
//
// Supported: add sub and or slt sll, addi lw sw beq, j jal.

module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_WIDTH      = 32,
    parameter logic        HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  halted,
    output logic                  dbg_we,
    output logic [4:0]            dbg_waddr,
    output logic [31:0]           dbg_wdata,
    output logic [ADDR_WIDTH-1:0] dbg_pc
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Architectural / sequencing state
    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
    logic [31:0]           ir_q, ir_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [31:0]           alu_q, alu_d;
    logic [31:0]           mdr_q, mdr_d;
    logic [31:0]           regs_q [0:31];

    // Registered outputs
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  halted_q, halted_d;
    logic                  dbg_we_q, dbg_we_d;
    logic [4:0]            dbg_waddr_q, dbg_waddr_d;
    logic [31:0]           dbg_wdata_q, dbg_wdata_d;

    // Register-file write port
    logic                  rf_we;
    logic [4:0]            rf_waddr;
    logic [31:0]           rf_wdata;

    // Instruction fields
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext;
    logic        legal;
    logic [31:0] pc4_ext;
    logic [31:0] alu_res;
    logic [ADDR_WIDTH-1:0] br_target, jmp_target;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;

    always_comb begin
        op       = ir_q[31:26];
        rs       = ir_q[25:21];
        rt       = ir_q[20:16];
        rd       = ir_q[15:11];
        shamt    = ir_q[10:6];
        fn       = ir_q[5:0];
        imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
        pc4_ext  = 32'(pc4_q);
    end

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                              (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_SLL);
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    // ALU; for jal it carries the link value so WB can treat it uniformly.
    always_comb begin
        alu_res = 32'h0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD:  alu_res = a_q + b_q;
                    FN_SUB:  alu_res = a_q - b_q;
                    FN_AND:  alu_res = a_q & b_q;
                    FN_OR:   alu_res = a_q | b_q;
                    FN_SLT:  alu_res = {31'h0, ($signed(a_q) < $signed(b_q))};
                    FN_SLL:  alu_res = b_q << shamt;
                    default: alu_res = 32'h0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_sext;
            OP_JAL:                alu_res = pc4_ext;
            default:               alu_res = 32'h0;
        endcase
    end

    // Targets are computed in 32 bits and truncated, so the PC wraps.
    always_comb begin
        br_target  = ADDR_WIDTH'(pc4_ext + (imm_sext << 2));
        jmp_target = ADDR_WIDTH'({pc4_ext[31:28], ir_q[25:0], 2'b00});
    end

    always_comb begin
        wb_dest = rt;
        if (op == OP_RTYPE) begin
            wb_dest = rd;
        end else if (op == OP_JAL) begin
            wb_dest = 5'd31;
        end
        wb_value = (op == OP_LW) ? mdr_q : alu_q;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        alu_d       = alu_q;
        mdr_d       = mdr_q;
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        rf_wdata    = 32'h0;
        dbg_we_d    = 1'b0;
        dbg_waddr_d = dbg_waddr_q;
        dbg_wdata_d = dbg_wdata_q;

        case (state_q)
            S_FETCH: begin
                if (mem_req_q && mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = regs_q[rs];
                b_d   = regs_q[rt];
                pc4_d = pc_q + ADDR_WIDTH'(4);
                if (!legal) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_WIDTH'(4);
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                case (op)
                    OP_BEQ: begin
                        pc_d    = (a_q == b_q) ? br_target : pc4_q;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = jmp_target;
                        state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_d    = jmp_target;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        // Misaligned data address stops the core with PC
                        // still pointing at the offending instruction.
                        state_d = (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_req_q && mem_ready) begin
                    if (op == OP_SW) begin
                        pc_d    = pc4_q;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                if (wb_dest != 5'd0) begin
                    rf_we       = 1'b1;
                    rf_waddr    = wb_dest;
                    rf_wdata    = wb_value;
                    dbg_we_d    = 1'b1;
                    dbg_waddr_d = wb_dest;
                    dbg_wdata_d = wb_value;
                end
                // jal already loaded its jump target in EXEC.
                if (op != OP_JAL) begin
                    pc_d = pc4_q;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Output registers are loaded from the state being entered, so a request
    // is already on the port during the first cycle of FETCH/MEM. Right after
    // reset mem_req is 0 in FETCH, costing one idle cycle before the first
    // fetch goes out.
    always_comb begin
        mem_req_d   = (state_d == S_FETCH) || (state_d == S_MEM);
        mem_we_d    = (state_d == S_MEM) && (op == OP_SW);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_d == S_FETCH) begin
            mem_addr_d = pc_d;
        end else if (state_d == S_MEM) begin
            mem_addr_d  = ADDR_WIDTH'(alu_d);
            mem_wdata_d = b_q;
        end
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= ADDR_WIDTH'(RESET_PC);
            pc4_q       <= '0;
            ir_q        <= 32'h0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            alu_q       <= 32'h0;
            mdr_q       <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            halted_q    <= 1'b0;
            dbg_we_q    <= 1'b0;
            dbg_waddr_q <= 5'd0;
            dbg_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alu_q       <= alu_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
            dbg_we_q    <= dbg_we_d;
            dbg_waddr_q <= dbg_waddr_d;
            dbg_wdata_q <= dbg_wdata_d;
        end
    end

    // Register file; $0 is never written so it always reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign dbg_we    = dbg_we_q;
    assign dbg_waddr = dbg_waddr_q;
    assign dbg_wdata = dbg_wdata_q;
    assign dbg_pc    = pc_q;

endmodule
